// File: rtl/lamp_mon_pkg.sv
// Shared types and constants for the lamp monitor: FSM states, fault codes and lamp patterns.
package lamp_mon_pkg;

    typedef enum logic [1:0] {
        StMonitor,
        StFault,
        StRecover
    } state_e;

    typedef logic [2:0] fault_code_t;

    localparam fault_code_t FaultNone        = 3'd0;
    localparam fault_code_t FaultConflict    = 3'd1;
    localparam fault_code_t FaultOneHot      = 3'd2;
    localparam fault_code_t FaultStep        = 3'd3;
    localparam fault_code_t FaultShortYellow = 3'd4;
    localparam fault_code_t FaultStuck       = 3'd5;

    typedef struct packed {
        logic g;
        logic y;
        logic r;
    } lamp_t;

    localparam lamp_t LampOff    = '{g: 1'b0, y: 1'b0, r: 1'b0};
    localparam lamp_t LampRed    = '{g: 1'b0, y: 1'b0, r: 1'b1};
    localparam lamp_t LampYellow = '{g: 1'b0, y: 1'b1, r: 1'b0};
    localparam lamp_t LampGreen  = '{g: 1'b1, y: 1'b0, r: 1'b0};

    function automatic logic lamp_onehot(lamp_t l);
        return (l == LampGreen) || (l == LampYellow) || (l == LampRed);
    endfunction

endpackage

// File: rtl/approach_checker.sv
// Per-approach checks: exactly one lamp lit, legal G->Y->R->G stepping, minimum yellow length.
module approach_checker
    import lamp_mon_pkg::*;
#(
    parameter int unsigned MIN_YELLOW_CYCLES = 10
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  clr_i,
    input  lamp_t lamp_i,
    input  lamp_t prev_i,
    output logic  onehot_err_o,
    output logic  step_err_o,
    output logic  short_y_err_o
);

    logic [15:0] ycnt_q, ycnt_d;
    logic        step_ok;

    always_comb begin
        step_ok = (lamp_i == prev_i)
                || (prev_i == LampGreen  && lamp_i == LampYellow)
                || (prev_i == LampYellow && lamp_i == LampRed)
                || (prev_i == LampRed    && lamp_i == LampGreen);
        onehot_err_o  = !lamp_onehot(lamp_i);
        step_err_o    = !step_ok;
        // ycnt_q holds the number of yellow cycles seen so far when yellow falls
        short_y_err_o = prev_i.y && !lamp_i.y && (32'(ycnt_q) < MIN_YELLOW_CYCLES);

        ycnt_d = '0;
        if (!clr_i && lamp_i.y) begin
            ycnt_d = (ycnt_q == 16'hFFFF) ? ycnt_q : ycnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ycnt_q <= '0;
        end else begin
            ycnt_q <= ycnt_d;
        end
    end

endmodule

// File: rtl/lamp_monitor.sv
// Traffic-lamp safety monitor: mirrors lamp requests, latches the first fault, flashes red until
// acknowledged. Define LAMP_MON_STUCK_CHECK_EN to compile in the stuck-pattern (code 5) check.
module lamp_monitor
    import lamp_mon_pkg::*;
#(
    parameter int unsigned MIN_YELLOW_CYCLES = 10,
    parameter int unsigned MAX_PHASE_CYCLES  = 1000,
    parameter int unsigned FLASH_HALF_CYCLES = 25,
    parameter int unsigned ALLRED_CYCLES     = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ns_g_i,
    input  logic       ns_y_i,
    input  logic       ns_r_i,
    input  logic       ew_g_i,
    input  logic       ew_y_i,
    input  logic       ew_r_i,
    input  logic       clear_fault,
    output logic       ns_g,
    output logic       ns_y,
    output logic       ns_r,
    output logic       ew_g,
    output logic       ew_y,
    output logic       ew_r,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam logic [15:0] FlashHalf  = 16'(FLASH_HALF_CYCLES);
    localparam logic [15:0] FlashLast  = 16'(2 * FLASH_HALF_CYCLES - 1);
    localparam logic [15:0] AllredLast = 16'(ALLRED_CYCLES - 1);

    state_e      state_q, state_d;
    lamp_t       ns_in, ew_in;
    lamp_t       ns_out_q, ns_out_d, ew_out_q, ew_out_d;
    lamp_t       ns_prev_q, ns_prev_d, ew_prev_q, ew_prev_d;
    fault_code_t code_q, code_d, det;
    logic [15:0] phase_cnt_q, phase_cnt_d;
    logic        chk_clr;
    logic        ns_oh_err, ns_step_err, ns_sy_err;
    logic        ew_oh_err, ew_step_err, ew_sy_err;
    logic        stuck_err;

    assign ns_in   = '{g: ns_g_i, y: ns_y_i, r: ns_r_i};
    assign ew_in   = '{g: ew_g_i, y: ew_y_i, r: ew_r_i};
    assign chk_clr = (state_q != StMonitor);

    approach_checker #(.MIN_YELLOW_CYCLES(MIN_YELLOW_CYCLES)) u_ns_chk (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr_i        (chk_clr),
        .lamp_i       (ns_in),
        .prev_i       (ns_prev_q),
        .onehot_err_o (ns_oh_err),
        .step_err_o   (ns_step_err),
        .short_y_err_o(ns_sy_err)
    );

    approach_checker #(.MIN_YELLOW_CYCLES(MIN_YELLOW_CYCLES)) u_ew_chk (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr_i        (chk_clr),
        .lamp_i       (ew_in),
        .prev_i       (ew_prev_q),
        .onehot_err_o (ew_oh_err),
        .step_err_o   (ew_step_err),
        .short_y_err_o(ew_sy_err)
    );

`ifdef LAMP_MON_STUCK_CHECK_EN
    logic [15:0] stuck_cnt_q, stuck_cnt_d, run_len;

    // run_len is the length of the current unchanged run including this cycle
    always_comb begin
        run_len = 16'd1;
        if ({ns_in, ew_in} == {ns_prev_q, ew_prev_q}) begin
            run_len = (stuck_cnt_q == 16'hFFFF) ? stuck_cnt_q : stuck_cnt_q + 16'd1;
        end
        stuck_err   = (32'(run_len) >= MAX_PHASE_CYCLES);
        stuck_cnt_d = (state_q == StMonitor) ? run_len : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stuck_cnt_q <= '0;
        end else begin
            stuck_cnt_q <= stuck_cnt_d;
        end
    end
`else
    assign stuck_err = 1'b0;
`endif

    always_comb begin
        det = FaultNone;
        if (!ns_in.r && !ew_in.r) begin
            det = FaultConflict;
        end else if (ns_oh_err || ew_oh_err) begin
            det = FaultOneHot;
        end else if (ns_step_err || ew_step_err) begin
            det = FaultStep;
        end else if (ns_sy_err || ew_sy_err) begin
            det = FaultShortYellow;
        end else if (stuck_err) begin
            det = FaultStuck;
        end
    end

    always_comb begin
        state_d     = state_q;
        ns_out_d    = ns_out_q;
        ew_out_d    = ew_out_q;
        ns_prev_d   = LampRed;
        ew_prev_d   = LampRed;
        code_d      = code_q;
        phase_cnt_d = phase_cnt_q;
        unique case (state_q)
            StMonitor: begin
                if (det != FaultNone) begin
                    state_d     = StFault;
                    code_d      = det;
                    phase_cnt_d = '0;
                    ns_out_d    = LampRed;
                    ew_out_d    = LampRed;
                end else begin
                    ns_out_d  = ns_in;
                    ew_out_d  = ew_in;
                    ns_prev_d = ns_in;
                    ew_prev_d = ew_in;
                end
            end
            StFault: begin
                if (clear_fault) begin
                    state_d     = StRecover;
                    phase_cnt_d = '0;
                    ns_out_d    = LampRed;
                    ew_out_d    = LampRed;
                end else begin
                    phase_cnt_d = (phase_cnt_q == FlashLast) ? '0 : phase_cnt_q + 16'd1;
                    ns_out_d    = (phase_cnt_d < FlashHalf) ? LampRed : LampOff;
                    ew_out_d    = ns_out_d;
                end
            end
            StRecover: begin
                ns_out_d = LampRed;
                ew_out_d = LampRed;
                if (phase_cnt_q == AllredLast) begin
                    state_d = StMonitor;
                    code_d  = FaultNone;
                end else begin
                    phase_cnt_d = phase_cnt_q + 16'd1;
                end
            end
            default: state_d = StMonitor;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StMonitor;
            ns_out_q    <= LampRed;
            ew_out_q    <= LampRed;
            ns_prev_q   <= LampRed;
            ew_prev_q   <= LampRed;
            code_q      <= FaultNone;
            phase_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ns_out_q    <= ns_out_d;
            ew_out_q    <= ew_out_d;
            ns_prev_q   <= ns_prev_d;
            ew_prev_q   <= ew_prev_d;
            code_q      <= code_d;
            phase_cnt_q <= phase_cnt_d;
        end
    end

    assign {ns_g, ns_y, ns_r} = ns_out_q;
    assign {ew_g, ew_y, ew_r} = ew_out_q;
    assign fault              = (state_q != StMonitor);
    assign fault_code         = code_q;

endmodule

// File: tb/tb_lamp_monitor.sv
// Directed bench for lamp_monitor with a behavioural model compared every cycle plus literal pins.
module tb_lamp_monitor;

    localparam int MIN_Y  = 10;
    localparam int MAX_PH = 100;
    localparam int HALF   = 5;
    localparam int ALLRED = 8;
`ifdef LAMP_MON_STUCK_CHECK_EN
    localparam bit STUCK_EN = 1'b1;
`else
    localparam bit STUCK_EN = 1'b0;
`endif
    localparam logic [2:0] G = 3'b100, Y = 3'b010, R = 3'b001, OFF = 3'b000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ns_g_i, ns_y_i, ns_r_i, ew_g_i, ew_y_i, ew_r_i, clear_fault;
    logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, fault;
    logic [2:0] fault_code;

    int checks = 0;
    int errors = 0;

    // model state: mode 0 = monitoring, 1 = flashing fault, 2 = all-red recovery
    int         m_mode, m_code, m_tick, m_yrun_ns, m_yrun_ew, m_run;
    logic [2:0] m_prev_ns, m_prev_ew, e_ns, e_ew;

    lamp_monitor #(
        .MIN_YELLOW_CYCLES(MIN_Y),
        .MAX_PHASE_CYCLES (MAX_PH),
        .FLASH_HALF_CYCLES(HALF),
        .ALLRED_CYCLES    (ALLRED)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ns_g_i     (ns_g_i),
        .ns_y_i     (ns_y_i),
        .ns_r_i     (ns_r_i),
        .ew_g_i     (ew_g_i),
        .ew_y_i     (ew_y_i),
        .ew_r_i     (ew_r_i),
        .clear_fault(clear_fault),
        .ns_g       (ns_g),
        .ns_y       (ns_y),
        .ns_r       (ns_r),
        .ew_g       (ew_g),
        .ew_y       (ew_y),
        .ew_r       (ew_r),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic [2:0] ns, input logic [2:0] ew);
        {ns_g_i, ns_y_i, ns_r_i} = ns;
        {ew_g_i, ew_y_i, ew_r_i} = ew;
    endtask

    function automatic bit legal(input logic [2:0] p, input logic [2:0] c);
        return (p == c) || (p == G && c == Y) || (p == Y && c == R) || (p == R && c == G);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_code = 0; m_tick = 0; m_yrun_ns = 0; m_yrun_ew = 0; m_run = 0;
        m_prev_ns = R; m_prev_ew = R; e_ns = R; e_ew = R;
    endtask

    task automatic model_step();
        logic [2:0] ns, ew;
        int c, run;
        ns = {ns_g_i, ns_y_i, ns_r_i};
        ew = {ew_g_i, ew_y_i, ew_r_i};
        if (m_mode == 0) begin
            run = ({ns, ew} == {m_prev_ns, m_prev_ew}) ? m_run + 1 : 1;
            c = 0;
            if (!ns[0] && !ew[0]) c = 1;
            else if ($countones(ns) != 1 || $countones(ew) != 1) c = 2;
            else if (!legal(m_prev_ns, ns) || !legal(m_prev_ew, ew)) c = 3;
            else if ((m_prev_ns[1] && !ns[1] && m_yrun_ns < MIN_Y) ||
                     (m_prev_ew[1] && !ew[1] && m_yrun_ew < MIN_Y)) c = 4;
            else if (STUCK_EN && run >= MAX_PH) c = 5;
            m_yrun_ns = ns[1] ? m_yrun_ns + 1 : 0;
            m_yrun_ew = ew[1] ? m_yrun_ew + 1 : 0;
            m_run = run;
            m_prev_ns = ns;
            m_prev_ew = ew;
            if (c != 0) begin
                m_mode = 1; m_code = c; m_tick = 0; e_ns = R; e_ew = R;
            end else begin
                e_ns = ns; e_ew = ew;
            end
        end else if (m_mode == 1) begin
            if (clear_fault) begin
                m_mode = 2; m_tick = 0; e_ns = R; e_ew = R;
            end else begin
                m_tick++;
                e_ns = ((m_tick % (2 * HALF)) < HALF) ? R : OFF;
                e_ew = e_ns;
            end
        end else begin
            m_tick++;
            e_ns = R; e_ew = R;
            if (m_tick == ALLRED) begin
                model_reset();
            end
        end
    endtask

    // Advance one clock: step the model on the edge, then compare every output just after it.
    task automatic tick();
        logic [11:0] got, exp;
        @(posedge clk);
        if (reset_n) model_step();
        #1;
        got = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, fault, fault_code};
        exp = {e_ns, e_ew, (m_mode != 0), 3'(m_code)};
        check("cycle", 32'(got), 32'(exp));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_clear();
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        ticks(ALLRED);
    endtask

    initial begin
        reset_n = 1'b0;
        clear_fault = 1'b0;
        set_in(R, R);
        model_reset();
        ticks(2);
        check("reset_lamps", 32'({ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}), 32'h09);
        check("reset_fault", 32'({fault, fault_code}), 32'h0);
        #2 reset_n = 1'b1;
        ticks(2);

        // Legal cycle: outputs mirror inputs one cycle late, no fault
        set_in(G, R);
        tick();
        check("mirror_ns_g", 32'(ns_g), 32'h1);
        for (int k = 0; k < 9; k++) begin
            set_in(G, R); ticks(k == 0 ? 49 : 50);
            set_in(Y, R); ticks(10);
            set_in(R, G); ticks(50);
            set_in(R, Y); ticks(10);
        end
        check("legal_no_fault", 32'(fault), 32'h0);
        set_in(G, R); ticks(3);

        // Conflict: both green
        set_in(G, G);
        tick();
        check("conflict_code", 32'({fault, fault_code}), 32'h9);
        check("flash_on", 32'({ns_g, ns_r, ew_r}), 32'h3);
        set_in(3'b111, 3'b111);
        ticks(HALF);
        check("flash_off", 32'({ns_r, ew_r}), 32'h0);
        ticks(HALF);
        check("flash_on_again", 32'({ns_r, ew_r}), 32'h3);

        // Acknowledge: ALLRED cycles solid red with fault high, then monitor
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        set_in(G, R);
        for (int i = 0; i < ALLRED; i++) begin
            check("recover_red", 32'({fault, ns_r, ew_r, ns_g}), 32'hE);
            tick();
        end
        check("recover_done", 32'({fault, fault_code}), 32'h0);
        tick();
        check("first_green", 32'({ns_g, fault}), 32'h2);

        // Short yellow: 6 cycles
        ticks(3);
        set_in(Y, R); ticks(6);
        set_in(R, R); tick();
        check("short_yellow", 32'(fault_code), 32'h4);
        set_in(G, R); do_clear();

        // Illegal G->R
        ticks(3);
        set_in(R, R); tick();
        check("step_g_to_r", 32'(fault_code), 32'h3);
        set_in(R, G); do_clear();

        // Illegal NS R->Y together with short EW yellow: step wins
        ticks(2);
        set_in(R, Y); ticks(3);
        set_in(Y, R); tick();
        check("step_over_yellow", 32'(fault_code), 32'h3);
        set_in(G, R); do_clear();

        // Two lamps on one approach
        ticks(2);
        set_in(3'b110, R); tick();
        check("not_onehot", 32'(fault_code), 32'h2);

        // Frozen pattern
        set_in(R, R); do_clear();
        ticks(MAX_PH - 1);
        check("stuck_before", 32'(fault), 32'h0);
        tick();
        check("stuck_at_limit", 32'({fault, fault_code}), STUCK_EN ? 32'hD : 32'h0);

        // Reset asserted mid-flash (during the dark half)
        do_clear();
        set_in(G, G); tick();
        ticks(HALF + 1);
        check("pre_reset_dark", 32'({fault, ns_r}), 32'h2);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_lamps", 32'({ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}), 32'h09);
        check("async_reset_fault", 32'({fault, fault_code}), 32'h0);
        set_in(R, R);
        ticks(2);
        #2 reset_n = 1'b1;
        ticks(3);
        set_in(G, R); ticks(3);
        check("post_reset_green", 32'({ns_g, ew_r, fault}), 32'h6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lamp_monitor.md
LAMP_MONITOR -- requirements
Module: lamp_monitor

Interface
REQ-001 SHALL have parameter MIN_YELLOW_CYCLES, default 10: minimum legal yellow duration per approach.
REQ-002 SHALL have parameter MAX_PHASE_CYCLES, default 1000: stuck-pattern limit; 16-bit counter.
REQ-003 SHALL have parameter FLASH_HALF_CYCLES, default 25: half-period of the fault red flash.
REQ-004 SHALL have parameter ALLRED_CYCLES, default 20: solid all-red hold after a fault is cleared.
REQ-005 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports ns_g_i, ns_y_i, ns_r_i, ew_g_i, ew_y_i, ew_r_i, input, 1 each: lamp requests from the upstream light controller.
REQ-008 SHALL have ports ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, output, 1 each: registered lamp drives.
REQ-009 SHALL have port clear_fault, input, 1: single-cycle fault acknowledge.
REQ-010 SHALL have port fault, output, 1: high while in FAULT or RECOVER.
REQ-011 SHALL have port fault_code, output, 3: first fault latched; 0 when no fault.

Function
REQ-012 SHALL implement FSM states MONITOR, FAULT, RECOVER.
REQ-013 In MONITOR, each output SHALL equal its input one cycle earlier, i.e. 1-cycle latency.
REQ-014 SHALL check each cycle in MONITOR, priority highest first: 1 conflict (ns_r_i=0 and ew_r_i=0); 2 not one-hot (an approach lit 0 or >=2 lamps); 3 illegal step; 4 short yellow; 5 stuck.
REQ-015 Legal per-approach steps SHALL be G->Y, Y->R, R->G and unchanged; any other change SHALL be code 3.
REQ-016 A per-approach yellow counter SHALL count cycles with yellow high; on yellow 1->0 with count < MIN_YELLOW_CYCLES, SHALL raise code 4.
REQ-017 The yellow counter SHALL clear when yellow falls.
REQ-018 The stuck counter SHALL count consecutive cycles of an unchanged 6-bit input pattern and SHALL raise code 5 when it reaches MAX_PHASE_CYCLES.
REQ-019 A fault detected in cycle N SHALL move to FAULT at edge N and latch fault_code; from cycle N+1, outputs SHALL be all-red flashing, red high for the first FLASH_HALF_CYCLES.
REQ-020 In FAULT, g/y outputs SHALL be 0 and inputs SHALL be ignored; simultaneous faults SHALL latch only the highest-priority code.
REQ-021 clear_fault in FAULT SHALL enter RECOVER: solid ns_r=ew_r=1 for ALLRED_CYCLES, then MONITOR with fault_code=0.
REQ-022 clear_fault in MONITOR or RECOVER SHALL be ignored.
REQ-023 On entry to MONITOR, the previous-sample register SHALL load all-red and all counters SHALL clear, so no false code 3 occurs.

Reset
REQ-024 reset_n low SHALL immediately set state=MONITOR, ns_r=ew_r=1, other lamps 0, fault=0, fault_code=0, counters 0, and previous-sample register to all-red.

Configuration
REQ-025 With LAMP_MON_STUCK_CHECK_EN defined, code-5 detection and its counter SHALL be compiled in.
REQ-026 Without LAMP_MON_STUCK_CHECK_EN, code 5 SHALL never be raised and the stuck counter SHALL not exist.

Structure
REQ-027 Package lamp_mon_pkg SHALL hold the FSM state typedef, fault-code constants (0-5) and the lamp-pattern typedef.
REQ-028 Sub-module approach_checker SHALL hold one-hot check, step legality and yellow counter; it SHALL be instantiated once per approach.

Verification
REQ-029 Legal sequence NS G(50) Y(10) / EW G(50) Y(10), MIN_YELLOW=10 -> outputs mirror inputs 1 cycle late; fault stays 0 for 1000 cycles.
REQ-030 Force ns_g_i=1 while ew_g_i=1 -> next cycle fault=1, fault_code=1, outputs all-red flashing with period 2*FLASH_HALF_CYCLES.
REQ-031 NS yellow held 6 cycles, MIN_YELLOW=10 -> fault_code=4 on the yellow-fall cycle.
REQ-032 NS G->R directly -> fault_code=3; a simultaneous short yellow on EW -> code stays 3.
REQ-033 Pulse clear_fault in FAULT, ALLRED_CYCLES=8 -> 8 cycles solid red with fault=1, then MONITOR, fault_code=0, and no fault on a first input of NS green.
REQ-034 Stuck check with macro defined, MAX_PHASE=100, pattern frozen -> code 5 at cycle 100; same stimulus with macro undefined -> no fault.
REQ-035 Assert reset_n mid-flash -> outputs immediately all-red solid, fault=0.
